muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It replaces the single-cycle HI/LO path with a multi-cycle engine. The engine supports signed and unsigned MULT/DIV, MTHI/MTLO writes, a busy/done handshake that the hazard unit uses to stall, and abort for pipeline flushes. It sits in EX beside the ALU; hi/lo feed the EXE result select mux.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Purpose : iterative signed/unsigned multiply/divide engine with architectural HI/LO
// Latency : DATA_WIDTH+1 cycles from the start edge to hi/lo update (1 cycle for divide-by-zero)
// Backpressure: busy is high while an operation is in flight; start/MTHI/MTLO must stall on busy
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   start, op, a, b   - launch MULTU(00)/MULT(01)/DIVU(10)/DIV(11) on a, b (sampled in IDLE only)
//   abort             - flush: drop the operation in flight, hi/lo untouched
//   hi_we, lo_we,wdata- MTHI/MTLO writes, honoured only while idle
//   hi, lo            - architectural HI/LO registers
//   busy, done        - engine active / one-cycle result-written pulse
//   div_by_zero       - qualifies the most recent done; held until the next one
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  abort,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int N = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(N - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] cnt;
  logic [N-1:0] acc_hi;   // product upper half / partial remainder
  logic [N-1:0] acc_lo;   // multiplier shifting out / dividend shifting out, quotient shifting in
  logic [N-1:0] opnd;     // |multiplicand| or |divisor|
  logic         is_div;
  logic         dz;       // divide by zero captured at start
  logic         neg_q;    // negate product / quotient
  logic         neg_r;    // negate remainder (dividend was negative)

  // Operand conditioning at start
  logic         a_neg, b_neg, b_zero;
  logic [N-1:0] a_abs, b_abs;

  assign a_neg  = op[0] & a[N-1];
  assign b_neg  = op[0] & b[N-1];
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  // One shift-add step: N+1 bit sum keeps the carry that shifts into acc_hi
  logic [N:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(N+1){1'b0}});

  // One restoring-divide step on the N+1 bit shifted remainder. The difference
  // always fits N bits when taken, since the old remainder was below the divisor.
  logic [N:0]   div_sh;
  logic         div_ge;
  logic [N-1:0] div_sub;
  assign div_sh  = {acc_hi, acc_lo[N-1]};
  assign div_ge  = (div_sh >= {1'b0, opnd});
  assign div_sub = div_sh[N-1:0] - opnd;

  // Sign correction applied in FIX
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   q_fix, r_fix;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -acc_lo : acc_lo;
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (op[1] && b_zero) ? FIX : CALC;
      CALC: begin
        if (abort)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            dz     <= op[1] & b_zero;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= CNT_INIT;
            if (op[1]) begin
              opnd <= b_abs;
              if (b_zero) begin
                // Preloaded so FIX just copies: hi = raw dividend, lo = all ones
                acc_hi <= a;
                acc_lo <= '1;
              end else begin
                acc_hi <= '0;
                acc_lo <= a_abs;
              end
            end else begin
              acc_hi <= '0;
              acc_lo <= b_abs;
              opnd   <= a_abs;
            end
          end
        end
        CALC: begin
          if (!abort) begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
            if (is_div) begin
              acc_hi <= div_ge ? div_sub : div_sh[N-1:0];
              acc_lo <= {acc_lo[N-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[N:1];
              acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
            end
          end
        end
        FIX: begin
          if (!abort) begin
            done        <= 1'b1;
            div_by_zero <= dz;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (dz) begin
              hi <= acc_hi;
              lo <= acc_lo;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
